// File: rtl/muldiv_hilo_ctrl.sv
// HI/LO write sequencer for the EX stage: multi-cycle MULT/MULTU, restoring DIV/DIVU,
// and single-cycle MTHI/MTLO, each ending in one registered HI/LO write strobe.
module muldiv_hilo_ctrl #(
  parameter int MUL_LAT  = 2,
  parameter int DIV_ITER = 32
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        op_valid,
  input  logic [2:0]  op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic [31:0] hi_cur,
  input  logic [31:0] lo_cur,
  input  logic        flush,
  output logic        stall_o,
  output logic        busy_o,
  output logic        hilo_we,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o
);

  localparam int DATA_W = 32;

  typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;

  state_t      state;
  logic [4:0]  cnt;

  logic is_mul, is_div, is_mthi, is_mtlo, is_sgn, accept;

  logic [DATA_W-1:0] a_p0, b_p0, rem_p0, quot_p0;
  logic              sgn_p0, qneg_p0, rneg_p0, div0_p0;

  logic signed [2*DATA_W-1:0] ma_p0, mb_p0, prod_p0;
  logic [DATA_W:0]            rem_sh;
  logic                       sub_ok;
  logic [DATA_W-1:0]          diff, rem_nxt, quot_nxt, q_fin, r_fin;

  function automatic logic [DATA_W-1:0] cond_neg(input logic [DATA_W-1:0] v, input logic n);
    return n ? (~v + 32'd1) : v;
  endfunction

  assign is_mul  = (op == 3'd1) || (op == 3'd2);
  assign is_div  = (op == 3'd3) || (op == 3'd4);
  assign is_mthi = (op == 3'd5);
  assign is_mtlo = (op == 3'd6);
  assign is_sgn  = (op == 3'd1) || (op == 3'd3);
  assign accept  = (state == IDLE) && op_valid && !flush;
  assign busy_o  = (state != IDLE);

  always_comb begin
    stall_o = 1'b0;
    if (rstn && !flush) begin
      case (state)
        IDLE:    stall_o = op_valid && (is_mul || is_div);
        MUL,
        DIV:     stall_o = (cnt != 5'd0);
        default: stall_o = 1'b0;
      endcase
    end
  end

  // Stage p0: operands captured on accept, then one divide iteration per DIV cycle
  always_ff @(posedge clk) begin
    if (accept && is_mul) begin
      a_p0   <= rs_val;
      b_p0   <= rt_val;
      sgn_p0 <= is_sgn;
    end else if (accept && is_div) begin
      a_p0    <= rs_val;
      quot_p0 <= cond_neg(rs_val, is_sgn & rs_val[31]);
      b_p0    <= cond_neg(rt_val, is_sgn & rt_val[31]);
      rem_p0  <= '0;
      qneg_p0 <= is_sgn & (rs_val[31] ^ rt_val[31]);
      rneg_p0 <= is_sgn & rs_val[31];
      div0_p0 <= (rt_val == '0);
    end else if (state == DIV) begin
      rem_p0  <= rem_nxt;
      quot_p0 <= quot_nxt;
    end
  end

  // Sign-extending to 64 bits makes the low 64 product bits right for both signednesses
  assign ma_p0   = {{DATA_W{sgn_p0 & a_p0[31]}}, a_p0};
  assign mb_p0   = {{DATA_W{sgn_p0 & b_p0[31]}}, b_p0};
  assign prod_p0 = ma_p0 * mb_p0;

  // A successful trial subtract leaves a remainder below the divisor, so 32 bits suffice
  assign rem_sh   = {rem_p0, quot_p0[31]};
  assign sub_ok   = (rem_sh >= {1'b0, b_p0});
  assign diff     = rem_sh[DATA_W-1:0] - b_p0;
  assign rem_nxt  = sub_ok ? diff : rem_sh[DATA_W-1:0];
  assign quot_nxt = {quot_p0[DATA_W-2:0], sub_ok};
  assign q_fin    = cond_neg(quot_nxt, qneg_p0);
  assign r_fin    = cond_neg(rem_nxt, rneg_p0);

  // Stage p1: FSM and registered HI/LO write port
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state   <= IDLE;
      cnt     <= 5'd0;
      hilo_we <= 1'b0;
      hi_o    <= '0;
      lo_o    <= '0;
    end else begin
      hilo_we <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            if (is_mul) begin
              state <= MUL;
              cnt   <= 5'(MUL_LAT - 1);
            end else if (is_div) begin
              state <= DIV;
              cnt   <= 5'(DIV_ITER - 1);
            end else if (is_mthi) begin
              hilo_we <= 1'b1;
              hi_o    <= rs_val;
              lo_o    <= lo_cur;
            end else if (is_mtlo) begin
              hilo_we <= 1'b1;
              hi_o    <= hi_cur;
              lo_o    <= rs_val;
            end
          end
        end
        MUL: begin
          if (flush) begin
            state <= IDLE;
            cnt   <= 5'd0;
          end else if (cnt == 5'd0) begin
            state        <= IDLE;
            hilo_we      <= 1'b1;
            {hi_o, lo_o} <= prod_p0;
          end else begin
            cnt <= cnt - 5'd1;
          end
        end
        DIV: begin
          if (flush) begin
            state <= IDLE;
            cnt   <= 5'd0;
          end else if (cnt == 5'd0) begin
            state   <= IDLE;
            hilo_we <= 1'b1;
            hi_o    <= div0_p0 ? a_p0 : r_fin;
            lo_o    <= div0_p0 ? 32'hFFFF_FFFF : q_fin;
          end else begin
            cnt <= cnt - 5'd1;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= 5'd0;
        end
      endcase
    end
  end

endmodule

// File: doc/muldiv_hilo_ctrl.md
Name: muldiv_hilo_ctrl

Overview:
Sequences every write to the HI/LO register pair in the EX stage of the MIPS core. It accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from EX, runs a MUL_LAT-cycle multiply or a 32-iteration restoring divide, and stalls the pipeline while busy. It then issues a single-cycle write (hilo_we, hi_o, lo_o) into the HI/LO register. It cancels in-flight work on pipeline flush.

Parameters:
MUL_LAT, 2, multiply cycles in MUL state (legal 1..4)
DIV_ITER, 32, divide iterations, one quotient bit per cycle (fixed at 32)

Ports:
clk  input  1  clock
rstn  input  1  reset, asynchronous, active-low
op_valid  input  1  EX holds a valid HI/LO-class op
op  input  3  0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 reserved (treated as NONE)
rs_val  input  32  rs operand (dividend / multiplicand / MTHI-MTLO data)
rt_val  input  32  rt operand (divisor / multiplier)
hi_cur  input  32  current HI register value
lo_cur  input  32  current LO register value
flush  input  1  pipeline flush (exception/eret)
stall_o  output  1  hold EX and earlier stages
busy_o  output  1  FSM not IDLE
hilo_we  output  1  one-cycle HI/LO write strobe (registered)
hi_o  output  32  HI write data (registered)
lo_o  output  32  LO write data (registered)

Behaviour:
- Reset (async, rstn=0): state=IDLE, counter=0, hilo_we=0, hi_o=lo_o=0, stall_o=0, busy_o=0. Reset mid-operation abandons the op with no write.
- FSM states: IDLE, MUL, DIV.
- Ops are accepted only in IDLE, when op_valid=1 and flush=0. Ops presented in MUL/DIV are ignored.
- Accept cycle A:
  - MUL/DIV op: capture operands and signedness; load counter (MUL_LAT-1 or 31); stall_o=1 combinationally in cycle A.
  - MTHI: no stall; cycle A+1 gives hilo_we=1, hi_o=rs_val, lo_o=lo_cur.
  - MTLO: no stall; cycle A+1 gives hilo_we=1, hi_o=hi_cur, lo_o=rs_val.
- MUL state occupies cycles A+1..A+MUL_LAT.
  - stall_o=1 in cycles A..A+MUL_LAT-1 and 0 in the last MUL cycle, so the instruction leaves EX on that edge.
  - Cycle A+MUL_LAT+1: hilo_we=1, {hi_o,lo_o}=64-bit product; state=IDLE.
  - MULT: signed x signed. MULTU: unsigned x unsigned.
- DIV state occupies cycles A+1..A+32.
  - Restoring divide on magnitudes: 64-bit shift of {rem,quot}; one bit per cycle; trial subtract of the 33-bit remainder.
  - stall_o=1 in cycles A..A+31 and 0 in A+32.
  - Cycle A+33: hilo_we=1, hi_o=remainder, lo_o=quotient.
- DIV sign rules: quotient negated if operand signs differ; remainder takes the dividend's sign.
  - 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0.
- Divide by zero (DIV or DIVU): same timing; hi_o=rs_val, lo_o=0xFFFFFFFF; no exception.
- hilo_we is high for exactly one cycle per accepted, unflushed op. Otherwise hilo_we=0 and hi_o/lo_o hold their last values.
- busy_o = (state != IDLE).
- flush=1 in any cycle:
  - FSM goes to IDLE on the next edge; no hilo_we for the in-flight or same-cycle op.
  - stall_o forced 0 that cycle.
  - A flush in the cycle where hilo_we is already 1 does not cancel that write.
- Back-to-back ops: the next op can be accepted in the hilo_we cycle (state is IDLE).
- Forwarding: EX-stage MFHI/MFLO in the hilo_we cycle must select hi_o/lo_o. The bypass mux belongs to EX, not this block.

Test Plan:
- MULT rs=0xFFFFFFFE (-2), rt=0x00000003, MUL_LAT=2 -> stall_o high cycles A..A+1; hilo_we=1 only in A+3; hi=0xFFFFFFFF, lo=0xFFFFFFFA. MULTU same operands -> hi=0x00000002, lo=0xFFFFFFFA.
- DIV rs=0xFFFFFFF9 (-7), rt=0x00000002 -> stall_o high exactly 32 cycles (A..A+31); hilo_we in A+33; lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU 100/7 -> lo=14, hi=2.
- DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0. DIVU 0x1234 / 0 -> hi=0x1234, lo=0xFFFFFFFF, same 33-cycle timing.
- MTHI rs=0xA5A5A5A5 with lo_cur=0x11 -> no stall; next cycle hilo_we=1, hi=0xA5A5A5A5, lo=0x11. MTLO immediately after -> second single write in the following cycle.
- flush at DIV cycle A+10 -> busy_o drops next edge; no hilo_we ever; hi_o/lo_o unchanged. A new MULTU accepted next cycle completes normally.
- rstn pulsed low mid-DIV (async, between edges) -> all outputs 0 immediately; after release, a DIVU 9/3 yields lo=3, hi=0.
